// File: rtl/seq_comparator_nb.sv
// Digit-serial magnitude comparator: walks two WIDTH-bit operands MSB-first,
// DIGIT bits per cycle, signed or unsigned, and stops at the first differing digit.
module seq_comparator_nb #(
  parameter  int WIDTH = 32,
  parameter  int DIGIT = 8,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic [CW-1:0]    cycles,
  output logic [1:0]       dbg_state
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [DIGIT-1:0] da, db;
  logic             accept;

  // Handshake: a request is taken on any edge where start=1 and the unit is
  // not in CMP (IDLE or DONE); start during CMP is simply dropped.
  assign accept = start && (state_q != S_CMP);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;

    da = a_q[idx_q*DIGIT +: DIGIT];
    db = b_q[idx_q*DIGIT +: DIGIT];
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (s_q && (idx_q == IW'(NDIG - 1))) begin
      da[DIGIT-1] = ~da[DIGIT-1];
      db[DIGIT-1] = ~db[DIGIT-1];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d  = S_CMP;
          a_d      = a;
          b_d      = b;
          s_d      = s;
          idx_d    = IW'(NDIG - 1);
          cnt_d    = '0;
          cycles_d = '0;
          eq_d     = 1'b0;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
        end
      end
      S_CMP: begin
        cnt_d = cnt_q + CW'(1);
        if (da > db) begin
          gt_d     = 1'b1;
          cycles_d = cnt_q + CW'(1);
          state_d  = S_DONE;
        end else if (da < db) begin
          lt_d     = 1'b1;
          cycles_d = cnt_q + CW'(1);
          state_d  = S_DONE;
        end else if (idx_q == '0) begin
          eq_d     = 1'b1;
          cycles_d = cnt_q + CW'(1);
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy      = (state_q == S_CMP);
  assign done      = (state_q == S_DONE);
  assign a_eq_b    = eq_q;
  assign a_gt_b    = gt_q;
  assign a_lt_b    = lt_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_comparator_nb.sv
// Bench for seq_comparator_nb: directed cases plus random operands against a
// digit-level reference model; a second 8/8 instance covers the single-digit case.
module tb_seq_comparator_nb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 32/8 instance
  logic        start = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        s_i = 1'b0;
  logic        busy, done, a_eq_b, a_gt_b, a_lt_b;
  logic [2:0]  cycles;
  logic [1:0]  dbg_state;

  // 8/8 instance
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8 = 1'b0;
  logic        busy8, done8, eq8, gt8, lt8;
  logic [0:0]  cycles8;
  logic [1:0]  dbg_state8;

  int checks = 0;
  int errors = 0;

  seq_comparator_nb #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .s(s_i),
    .busy(busy), .done(done), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
    .cycles(cycles), .dbg_state(dbg_state)
  );

  seq_comparator_nb #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .s(s8),
    .busy(busy8), .done(done8), .a_eq_b(eq8), .a_gt_b(gt8), .a_lt_b(lt8),
    .cycles(cycles8), .dbg_state(dbg_state8)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from plain signed/unsigned arithmetic; k is the
  // position (from the MSB end) of the first byte that differs, or 4 if none.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sg,
                       output bit eq, output bit gt, output bit lt, output int k);
    bit found;
    eq = (a == b);
    gt = sg ? ($signed(a) > $signed(b)) : (a > b);
    lt = sg ? ($signed(a) < $signed(b)) : (a < b);
    k = 4;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && (a[i*8 +: 8] != b[i*8 +: 8])) begin
        k = 4 - i;
        found = 1'b1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_flags"},  {a_eq_b, a_gt_b, a_lt_b}, 0);
    check({tag, "_cycles"}, cycles, 0);
  endtask

  // One transaction on the 32-bit instance. chain=1 means we are sitting in
  // the done cycle and start is driven so the DONE edge accepts it.
  // While n < noise, start is held high with junk operands during CMP.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit sg, input bit chain, input int noise);
    bit eq, gt, lt;
    int k, n;
    model(a, b, sg, eq, gt, lt, k);
    if (!chain) @(negedge clk);
    start = 1'b1; a_i = a; b_i = b; s_i = sg;
    @(posedge clk); #1;
    start = 1'b0; a_i = $urandom; b_i = $urandom; s_i = 1'($urandom_range(0, 1));
    check({tag, "_busy_on_accept"}, busy, 1);
    check({tag, "_flags_cleared"}, {a_eq_b, a_gt_b, a_lt_b}, 0);
    n = 0;
    if (noise > 0) start = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n < noise) begin
        start = 1'b1; a_i = $urandom; b_i = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n, k);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_flags"}, {a_eq_b, a_gt_b, a_lt_b}, {eq, gt, lt});
    check({tag, "_cycles"}, cycles, k);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit sg8, e8, g8, l8;
    logic [7:0] ta, tb;

    // 1: reset state, then a=b=0 unsigned
    #1;
    check_zero("rst_idle");
    check("rst_done8", done8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("eq_zero", 32'h0, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("hold_eq", a_eq_b, 1);
    check("hold_cycles", cycles, 4);
    rst_n = 1'b0; #1;
    check_zero("rst_after_result");
    @(negedge clk); rst_n = 1'b1;

    // 2: lowest vs highest deciding digit
    run_op("gt_lsb", 32'h0000_0001, 32'h0, 1'b0, 1'b0, 0);
    run_op("gt_msb", 32'h0100_0000, 32'h0, 1'b0, 1'b0, 0);

    // 3: sign handling on the MSB digit
    run_op("u_8000", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 0);
    run_op("s_8000", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    run_op("s_neg1", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 0);

    // 4: equal signed, start during busy is ignored; 5: back-to-back
    run_op("deadbeef", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 3);
    run_op("chain_5_9", 32'd5, 32'd9, 1'b0, 1'b1, 0);

    // 5: reset in the middle of a compare
    @(negedge clk);
    start = 1'b1; a_i = 32'h0; b_i = 32'h0; s_i = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst_n = 1'b0; #1;
    check_zero("mid_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op("after_abort", 32'h1234_5678, 32'h1234_0000, 1'b0, 1'b0, 0);

    // random operands sharing a random prefix so every k is exercised
    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      rb = ra;
      for (int d = 0; d < 4; d++)
        if ($urandom_range(0, 2) == 0) rb[d*8 +: 8] = 8'($urandom_range(0, 255));
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // 6: single-digit instance
    for (int i = 0; i < 2; i++) begin
      sg8 = (i == 0);
      ta = 8'hC0; tb = 8'h40;
      e8 = (ta == tb);
      g8 = sg8 ? ($signed(ta) > $signed(tb)) : (ta > tb);
      l8 = sg8 ? ($signed(ta) < $signed(tb)) : (ta < tb);
      @(negedge clk);
      start8 = 1'b1; a8 = ta; b8 = tb; s8 = sg8;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      check("w8_busy", busy8, 1);
      @(posedge clk); #1;
      check("w8_done", done8, 1);
      check("w8_flags", {eq8, gt8, lt8}, {e8, g8, l8});
      check("w8_cycles", cycles8, 1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
